// File: rtl/pwm_frame_sched_pkg.sv
// Shared types and the round-robin pick helper for the PWM frame scheduler.
// The helper is sized for the largest supported channel count (8).
package pwm_frame_sched_pkg;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned MAX_CH_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, walking upward and wrapping at nch.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0]   valid,
        input logic [MAX_CH_W-1:0] ptr,
        input logic [MAX_CH_W:0]   nch
    );
        rr_pick_t             res;
        logic [MAX_CH_W:0]    cand;
        res = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            cand = {1'b0, ptr} + (MAX_CH_W + 1)'(i);
            if (cand >= nch) begin
                cand = cand - nch;
            end
            if (((MAX_CH_W + 1)'(i) < nch) && !res.found && valid[cand[MAX_CH_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_CH_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_frame_sched_rr_arbiter.sv
// Combinational round-robin pick over a valid vector starting at a pointer.
// Reusable for any shared DDS resource with up to 8 requesters.
module rr_arbiter
    import pwm_frame_sched_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  valid,
    input  logic [CH_W-1:0] ptr,
    output logic            found_c,
    output logic [CH_W-1:0] grant_c
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_CH'(valid), MAX_CH_W'(ptr), (MAX_CH_W + 1)'(NCH));
        found_c = pick.found;
        grant_c = CH_W'(pick.idx);
    end

endmodule

// File: rtl/pwm_frame_sched.sv
// Frame-synchronous scheduler: one round-robin grant per PWM frame, duty
// register updated only on frame boundaries, underrun pulse and counter.
module pwm_frame_sched
    import pwm_frame_sched_pkg::*;
#(
    parameter int unsigned M        = 12,
    parameter int unsigned NCH      = 4,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned CH_W     = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH*M-1:0]    req_sample,
    output logic [NCH-1:0]      req_ready,
    output logic [M-1:0]        duty,
    output logic                frame_start,
    output logic [PWM_BITS-1:0] frame_cnt,
    output logic [CH_W-1:0]     active_ch,
    output logic                underrun,
    output logic [7:0]          urun_cnt,
    input  logic                urun_clr
);

    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NCH - 1);
    localparam logic [7:0]      URUN_MAX = 8'hFF;

    state_e                state_q, state_d;
    logic [PWM_BITS-1:0]   frame_cnt_q, frame_cnt_d;
    logic [M-1:0]          duty_q, duty_d;
    logic [CH_W-1:0]       active_ch_q, active_ch_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic [7:0]            urun_cnt_q, urun_cnt_d;

    logic                  last_c;
    logic                  found_c;
    logic [CH_W-1:0]       grant_c;

    rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .found_c (found_c),
        .grant_c (grant_c)
    );

    // Grant window is only the final cycle of a running frame.
    always_comb begin
        last_c    = (state_q == ST_RUN) && en && (frame_cnt_q == '1);
        req_ready = '0;
        if (last_c && found_c) begin
            req_ready[grant_c] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        duty_d        = duty_q;
        active_ch_d   = active_ch_q;
        rr_ptr_d      = rr_ptr_q;
        urun_cnt_d    = urun_cnt_q;

        case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + PWM_BITS'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                frame_cnt_d = '0;
            end
        endcase

        if (last_c && found_c) begin
            duty_d      = req_sample[32'(grant_c) * M +: M];
            active_ch_d = grant_c;
            rr_ptr_d    = (grant_c == LAST_CH) ? '0 : grant_c + CH_W'(1);
        end

        underrun_d = last_c && !found_c;

        // Clear wins over a coincident underrun increment.
        if (urun_clr) begin
            urun_cnt_d = '0;
        end else if (underrun_d && (urun_cnt_q != URUN_MAX)) begin
            urun_cnt_d = urun_cnt_q + 8'd1;
        end

        frame_start_d = (state_d == ST_RUN) && (frame_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            duty_q        <= '0;
            active_ch_q   <= '0;
            rr_ptr_q      <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            urun_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            duty_q        <= duty_d;
            active_ch_q   <= active_ch_d;
            rr_ptr_q      <= rr_ptr_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            urun_cnt_q    <= urun_cnt_d;
        end
    end

    assign duty        = duty_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign active_ch   = active_ch_q;
    assign underrun    = underrun_q;
    assign urun_cnt    = urun_cnt_q;

endmodule

// File: tb/tb_pwm_frame_sched.sv
// Directed bench for pwm_frame_sched: round-robin grants, frame timing,
// underrun counting/saturation, enable drop and asynchronous reset.
module tb_pwm_frame_sched;

    localparam int unsigned M        = 12;
    localparam int unsigned NCH      = 4;
    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned CH_W     = 2;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [NCH-1:0]      req_valid;
    logic [NCH*M-1:0]    req_sample;
    logic [NCH-1:0]      req_ready;
    logic [M-1:0]        duty;
    logic                frame_start;
    logic [PWM_BITS-1:0] frame_cnt;
    logic [CH_W-1:0]     active_ch;
    logic                underrun;
    logic [7:0]          urun_cnt;
    logic                urun_clr;

    int vectors;
    int miscompares;

    pwm_frame_sched #(
        .M        (M),
        .NCH      (NCH),
        .PWM_BITS (PWM_BITS),
        .CH_W     (CH_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_sample  (req_sample),
        .req_ready   (req_ready),
        .duty        (duty),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .active_ch   (active_ch),
        .underrun    (underrun),
        .urun_cnt    (urun_cnt),
        .urun_clr    (urun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; urun_clr = 1'b0; req_valid = '0; req_sample = '0;
        #12;
        vectors++;
        if ({duty, frame_cnt, active_ch, frame_start, underrun, urun_cnt, req_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got duty=%h cnt=%0d ch=%0d fs=%b ur=%b uc=%0d rdy=%b exp all zero",
                     duty, frame_cnt, active_ch, frame_start, underrun, urun_cnt, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [M-1:0]    exp_duty [5] = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h400};
        logic [CH_W-1:0] exp_ch   [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [NCH-1:0]  exp_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_valid  = 4'b1111;
        req_sample = {12'h400, 12'h300, 12'h200, 12'h100};
        en = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (frame_cnt !== PWM_BITS'(k) || frame_start !== (k == 0)) begin
                    miscompares++;
                    $display("FAIL rr_frame f=%0d k=%0d got cnt=%0d fs=%b exp cnt=%0d fs=%b",
                             f, k, frame_cnt, frame_start, k, (k == 0));
                end
                vectors++;
                if (duty !== exp_duty[f] || active_ch !== exp_ch[f]) begin
                    miscompares++;
                    $display("FAIL rr_duty f=%0d k=%0d got duty=%h ch=%0d exp duty=%h ch=%0d",
                             f, k, duty, active_ch, exp_duty[f], exp_ch[f]);
                end
                vectors++;
                if (req_ready !== ((k == 15) ? exp_rdy[f] : 4'b0000)) begin
                    miscompares++;
                    $display("FAIL rr_ready f=%0d k=%0d got=%b exp=%b",
                             f, k, req_ready, (k == 15) ? exp_rdy[f] : 4'b0000);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_single_channel();
        logic [M-1:0]    exp_duty [3] = '{12'h100, 12'hABC, 12'hABC};
        logic [CH_W-1:0] exp_ch   [3] = '{2'd0, 2'd2, 2'd2};
        req_valid = 4'b0100;
        req_sample[2*M +: M] = 12'hABC;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) req_sample[2*M +: M] = 12'h555;
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (duty !== exp_duty[f] || active_ch !== exp_ch[f]) begin
                    miscompares++;
                    $display("FAIL single_duty f=%0d k=%0d got duty=%h ch=%0d exp duty=%h ch=%0d",
                             f, k, duty, active_ch, exp_duty[f], exp_ch[f]);
                end
                vectors++;
                if (req_ready !== ((k == 15) ? 4'b0100 : 4'b0000)) begin
                    miscompares++;
                    $display("FAIL single_ready f=%0d k=%0d got=%b exp=%b",
                             f, k, req_ready, (k == 15) ? 4'b0100 : 4'b0000);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_underrun();
        logic       exp_ur [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_uc [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
        req_valid = 4'b0000;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (duty !== 12'h555 || active_ch !== 2'd2 || req_ready !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL urun_hold f=%0d k=%0d got duty=%h ch=%0d rdy=%b exp duty=555 ch=2 rdy=0000",
                             f, k, duty, active_ch, req_ready);
                end
                vectors++;
                if (underrun !== ((k == 0) && exp_ur[f]) || urun_cnt !== exp_uc[f]) begin
                    miscompares++;
                    $display("FAIL urun_pulse f=%0d k=%0d got ur=%b uc=%0d exp ur=%b uc=%0d",
                             f, k, underrun, urun_cnt, (k == 0) && exp_ur[f], exp_uc[f]);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (underrun !== 1'b1 || urun_cnt !== 8'd4) begin
            miscompares++;
            $display("FAIL urun_fourth got ur=%b uc=%0d exp ur=1 uc=4", underrun, urun_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        repeat (300 * 16) @(negedge clk);
        repeat (15) @(negedge clk);
        vectors++;
        if (frame_cnt !== 4'd15 || urun_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL urun_saturate got cnt=%0d uc=%0d exp cnt=15 uc=255", frame_cnt, urun_cnt);
        end
        urun_clr = 1'b1;
        @(negedge clk);
        urun_clr = 1'b0;
        vectors++;
        if (underrun !== 1'b1 || urun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL urun_clear_wins got ur=%b uc=%0d exp ur=1 uc=0", underrun, urun_cnt);
        end
    endtask

    task automatic test_en_drop();
        req_valid = 4'b0001;
        req_sample[0 +: M] = 12'h777;
        repeat (7) @(negedge clk);
        vectors++;
        if (frame_cnt !== 4'd7) begin
            miscompares++;
            $display("FAIL endrop_pos got cnt=%0d exp 7", frame_cnt);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (frame_cnt !== 4'd0 || frame_start !== 1'b0 || req_ready !== 4'b0000 || duty !== 12'h555) begin
                miscompares++;
                $display("FAIL endrop_idle i=%0d got cnt=%0d fs=%b rdy=%b duty=%h exp cnt=0 fs=0 rdy=0000 duty=555",
                         i, frame_cnt, frame_start, req_ready, duty);
            end
        end
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (frame_cnt !== PWM_BITS'(k) || duty !== 12'h555 ||
                req_ready !== ((k == 15) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("FAIL endrop_resume k=%0d got cnt=%0d duty=%h rdy=%b exp cnt=%0d duty=555 rdy=%b",
                         k, frame_cnt, duty, req_ready, k, (k == 15) ? 4'b0001 : 4'b0000);
            end
            @(negedge clk);
        end
        vectors++;
        if (duty !== 12'h777 || active_ch !== 2'd0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL endrop_grant got duty=%h ch=%0d fs=%b exp duty=777 ch=0 fs=1", duty, active_ch, frame_start);
        end
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0010;
        req_sample[1*M +: M] = 12'h999;
        repeat (16) @(negedge clk);
        vectors++;
        if (duty !== 12'h999 || active_ch !== 2'd1) begin
            miscompares++;
            $display("FAIL areset_pre got duty=%h ch=%0d exp duty=999 ch=1", duty, active_ch);
        end
        req_valid = 4'b1010;
        req_sample[1*M +: M] = 12'h1A1;
        req_sample[3*M +: M] = 12'h3A3;
        repeat (15) @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL areset_ready_before got=%b exp=1000", req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({duty, frame_cnt, active_ch, frame_start, underrun, urun_cnt, req_ready} !== '0) begin
            miscompares++;
            $display("FAIL areset_immediate got duty=%h cnt=%0d ch=%0d fs=%b ur=%b uc=%0d rdy=%b exp all zero",
                     duty, frame_cnt, active_ch, frame_start, underrun, urun_cnt, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 4'd0 || frame_start !== 1'b1 || duty !== 12'h000) begin
            miscompares++;
            $display("FAIL areset_restart got cnt=%0d fs=%b duty=%h exp cnt=0 fs=1 duty=000", frame_cnt, frame_start, duty);
        end
        repeat (15) @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL areset_first_grant got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (duty !== 12'h1A1 || active_ch !== 2'd1) begin
            miscompares++;
            $display("FAIL areset_duty got duty=%h ch=%0d exp duty=1A1 ch=1", duty, active_ch);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_underrun();
        test_saturate_clear();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
